// File: rtl/mpcache_pkg.sv
// mpcache_pkg: shared constants and types for the packet-SRAM block allocator.
//   BLK_ADDR_WIDTH : SRAM word-address width
//   BLK_WORDS      : words per block (power of two)
//   NUM_BLKS       : number of blocks = free-list depth
//   CNT_WIDTH      : free-count width (holds 0..NUM_BLKS)
//   alloc_state_t  : allocator FSM states
package mpcache_pkg;

    localparam int BLK_ADDR_WIDTH = 12;
    localparam int BLK_WORDS      = 16;
    localparam int NUM_BLKS       = (2 ** BLK_ADDR_WIDTH) / BLK_WORDS;
    localparam int CNT_WIDTH      = $clog2(NUM_BLKS) + 1;
    localparam int PTR_WIDTH      = $clog2(NUM_BLKS);
    localparam int OFS_WIDTH      = $clog2(BLK_WORDS);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } alloc_state_t;

    // Block index -> block base address. Since NUM_BLKS*BLK_WORDS spans the
    // whole address space, the index simply occupies the upper address bits.
    function automatic logic [BLK_ADDR_WIDTH-1:0] blk_base(input logic [PTR_WIDTH-1:0] idx);
        return {idx, {OFS_WIDTH{1'b0}}};
    endfunction

endpackage

// File: rtl/blk_addr_alloc_free_fifo.sv
// free_fifo: synchronous FIFO holding free block base addresses.
//   clk, rst   : clock, asynchronous active-high reset (pointers and count)
//   push       : write push_data at the tail
//   push_data  : address to store
//   pop        : advance the head
//   head       : current head entry (combinational read)
//   count      : number of stored entries, 0..NUM_BLKS
// The caller guarantees no push when full and no pop when empty; a push and a
// pop in the same cycle are both performed.
module free_fifo
    import mpcache_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [BLK_ADDR_WIDTH-1:0] push_data,
    input  logic                      pop,
    output logic [BLK_ADDR_WIDTH-1:0] head,
    output logic [CNT_WIDTH-1:0]      count
);

    logic [BLK_ADDR_WIDTH-1:0] mem [NUM_BLKS];
    logic [PTR_WIDTH-1:0]      wr_ptr;
    logic [PTR_WIDTH-1:0]      rd_ptr;
    logic [CNT_WIDTH-1:0]      cnt;

    // Storage carries no reset; only entries below the count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at NUM_BLKS; the separate count resolves
    // full versus empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/blk_addr_alloc.sv
// blk_addr_alloc: free-block allocator for the shared packet SRAM.
// After reset it loads every block base address into a free list, one per
// cycle, then grants one address per request in FIFO order and takes back
// released addresses at the tail.
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   i_addr_req      : one-cycle block request pulse
//   o_blk_addr_vld  : one-cycle grant strobe
//   o_blk_addr      : granted block base address (0 when no grant)
//   i_rel_vld       : release strobe
//   i_rel_addr      : released block base address
//   o_free_cnt      : number of free blocks in the list
//   o_init_done     : free list fully populated
//   o_err           : sticky protocol error
module blk_addr_alloc
    import mpcache_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_addr_req,
    output logic                      o_blk_addr_vld,
    output logic [BLK_ADDR_WIDTH-1:0] o_blk_addr,
    input  logic                      i_rel_vld,
    input  logic [BLK_ADDR_WIDTH-1:0] i_rel_addr,
    output logic [CNT_WIDTH-1:0]      o_free_cnt,
    output logic                      o_init_done,
    output logic                      o_err
);

    alloc_state_t              state;
    alloc_state_t              state_next;
    logic [PTR_WIDTH-1:0]      init_idx;
    logic                      pend;
    logic                      pend_next;

    logic                      push;
    logic [BLK_ADDR_WIDTH-1:0] push_data;
    logic                      pop;
    logic [BLK_ADDR_WIDTH-1:0] head;
    logic [CNT_WIDTH-1:0]      count;

    logic                      grant;
    logic                      err_set;

    logic                      vld_p1;
    logic [BLK_ADDR_WIDTH-1:0] blk_addr_p1;
    logic                      init_done;
    logic                      err;

    free_fifo u_free_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_comb begin
        state_next = state;
        push       = 1'b0;
        push_data  = '0;
        pop        = 1'b0;
        grant      = 1'b0;
        err_set    = 1'b0;

        case (state)
            S_INIT: begin
                push      = 1'b1;
                push_data = blk_base(init_idx);
                if (init_idx == PTR_WIDTH'(NUM_BLKS - 1)) begin
                    state_next = S_RUN;
                end
                // The list is still being built; a release now is dropped.
                if (i_rel_vld) begin
                    err_set = 1'b1;
                end
            end
            S_RUN: begin
                // Grant only from what is already in the list: a release
                // landing this cycle becomes grantable on the next edge.
                if (pend && (count != '0)) begin
                    grant = 1'b1;
                    pop   = 1'b1;
                end
                // Full is judged on the current count, even if a pop frees a
                // slot in the same cycle.
                if (i_rel_vld) begin
                    if ((i_rel_addr[OFS_WIDTH-1:0] != '0) ||
                        (count == CNT_WIDTH'(NUM_BLKS))) begin
                        err_set = 1'b1;
                    end else begin
                        push      = 1'b1;
                        push_data = i_rel_addr;
                    end
                end
            end
            default: state_next = S_INIT;
        endcase

        // Only one request can be outstanding; a second one is not queued.
        if (i_addr_req && pend) begin
            err_set = 1'b1;
        end

        pend_next = grant ? 1'b0 : (pend | i_addr_req);
    end

    // ---- output stage: grant strobe, address and status registered ----
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_INIT;
            init_idx    <= '0;
            pend        <= 1'b0;
            vld_p1      <= 1'b0;
            blk_addr_p1 <= '0;
            init_done   <= 1'b0;
            err         <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_INIT) begin
                init_idx <= init_idx + 1'b1;
            end
            pend        <= pend_next;
            vld_p1      <= grant;
            blk_addr_p1 <= grant ? head : '0;
            init_done   <= (state_next == S_RUN);
            err         <= err | err_set;
        end
    end

    assign o_blk_addr_vld = vld_p1;
    assign o_blk_addr     = blk_addr_p1;
    assign o_free_cnt     = count;
    assign o_init_done    = init_done;
    assign o_err          = err;

endmodule

// File: tb/tb_blk_addr_alloc.sv
module tb_blk_addr_alloc;

    logic        i_clk;
    logic        i_rst;
    logic        i_addr_req;
    logic        o_blk_addr_vld;
    logic [11:0] o_blk_addr;
    logic        i_rel_vld;
    logic [11:0] i_rel_addr;
    logic [8:0]  o_free_cnt;
    logic        o_init_done;
    logic        o_err;

    int n_cmp;
    int n_bad;

    blk_addr_alloc dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_addr_req     (i_addr_req),
        .o_blk_addr_vld (o_blk_addr_vld),
        .o_blk_addr     (o_blk_addr),
        .i_rel_vld      (i_rel_vld),
        .i_rel_addr     (i_rel_addr),
        .o_free_cnt     (o_free_cnt),
        .o_init_done    (o_init_done),
        .o_err          (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Reset, then wait the 256 init edges; returns just after edge 256.
    task automatic reset_and_init();
        i_rst = 1'b1; i_addr_req = 1'b0; i_rel_vld = 1'b0; i_rel_addr = '0;
        step(2);
        i_rst = 1'b0;
        step(256);
    endtask

    // One isolated request: sampled at edge k, grant visible after edge k+1.
    task automatic request_one(input logic [11:0] exp_addr, input string tag);
        i_addr_req = 1'b1;
        step(1);
        i_addr_req = 1'b0;
        step(1);
        n_cmp++;
        if (o_blk_addr_vld !== 1'b1 || o_blk_addr !== exp_addr) begin
            n_bad++;
            $display("FAIL %s: vld=%0b addr=%03h, want vld=1 addr=%03h", tag, o_blk_addr_vld, o_blk_addr, exp_addr);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_addr_req = 1'b0; i_rel_vld = 1'b0; i_rel_addr = '0;
        step(2);
        n_cmp++;
        if ({o_blk_addr_vld, o_blk_addr, o_free_cnt, o_init_done, o_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: vld=%0b addr=%03h cnt=%0d done=%0b err=%0b, want all 0",
                     o_blk_addr_vld, o_blk_addr, o_free_cnt, o_init_done, o_err);
        end
        i_rst = 1'b0;
        step(1);
        n_cmp++;
        if (o_free_cnt !== 9'd1) begin
            n_bad++; $display("FAIL init_cnt_e1: got %0d want 1", o_free_cnt);
        end
        step(1);
        n_cmp++;
        if (o_free_cnt !== 9'd2) begin
            n_bad++; $display("FAIL init_cnt_e2: got %0d want 2", o_free_cnt);
        end
        step(253);
        n_cmp++;
        if (o_free_cnt !== 9'd255 || o_init_done !== 1'b0) begin
            n_bad++; $display("FAIL init_e255: cnt=%0d done=%0b, want cnt=255 done=0", o_free_cnt, o_init_done);
        end
        step(1);
        n_cmp++;
        if (o_free_cnt !== 9'd256 || o_init_done !== 1'b1 || o_err !== 1'b0) begin
            n_bad++; $display("FAIL init_e256: cnt=%0d done=%0b err=%0b, want cnt=256 done=1 err=0",
                              o_free_cnt, o_init_done, o_err);
        end
    endtask

    task automatic test_init_pending();
        i_rst = 1'b1; i_addr_req = 1'b0; i_rel_vld = 1'b0; i_rel_addr = '0;
        step(2);
        i_rst = 1'b0;
        step(9);
        i_addr_req = 1'b1;
        step(1);             // edge 10 samples the request
        i_addr_req = 1'b0;
        step(246);           // edge 256
        n_cmp++;
        if (o_blk_addr_vld !== 1'b0 || o_init_done !== 1'b1) begin
            n_bad++; $display("FAIL initreq_e256: vld=%0b done=%0b, want vld=0 done=1", o_blk_addr_vld, o_init_done);
        end
        step(1);             // edge 257
        n_cmp++;
        if (o_blk_addr_vld !== 1'b1 || o_blk_addr !== 12'h000 || o_free_cnt !== 9'd255 || o_err !== 1'b0) begin
            n_bad++; $display("FAIL initreq_e257: vld=%0b addr=%03h cnt=%0d err=%0b, want 1 000 255 0",
                              o_blk_addr_vld, o_blk_addr, o_free_cnt, o_err);
        end
        step(1);
        n_cmp++;
        if (o_blk_addr_vld !== 1'b0 || o_blk_addr !== 12'h000) begin
            n_bad++; $display("FAIL initreq_e258: vld=%0b addr=%03h, want 0 000", o_blk_addr_vld, o_blk_addr);
        end
    endtask

    task automatic test_grants();
        logic [11:0] exp_addr;
        reset_and_init();
        for (int i = 0; i < 3; i++) begin
            exp_addr = 12'(i * 16);
            i_addr_req = 1'b1;
            step(1);
            i_addr_req = 1'b0;
            n_cmp++;
            if (o_blk_addr_vld !== 1'b0) begin
                n_bad++; $display("FAIL grant%0d_early: vld=%0b want 0", i, o_blk_addr_vld);
            end
            step(1);
            n_cmp++;
            if (o_blk_addr_vld !== 1'b1 || o_blk_addr !== exp_addr) begin
                n_bad++; $display("FAIL grant%0d: vld=%0b addr=%03h, want 1 %03h", i, o_blk_addr_vld, o_blk_addr, exp_addr);
            end
            step(1);
            n_cmp++;
            if (o_blk_addr_vld !== 1'b0 || o_blk_addr !== 12'h000) begin
                n_bad++; $display("FAIL grant%0d_drop: vld=%0b addr=%03h, want 0 000", i, o_blk_addr_vld, o_blk_addr);
            end
            step(1);
        end
        n_cmp++;
        if (o_free_cnt !== 9'd253) begin
            n_bad++; $display("FAIL grants_cnt: got %0d want 253", o_free_cnt);
        end
    endtask

    task automatic test_drain_release();
        for (int i = 0; i < 253; i++) begin
            request_one(12'(12'h030 + i * 16), "drain");
        end
        n_cmp++;
        if (o_free_cnt !== 9'd0 || o_err !== 1'b0) begin
            n_bad++; $display("FAIL drain_cnt: cnt=%0d err=%0b, want 0 0", o_free_cnt, o_err);
        end
        i_addr_req = 1'b1;
        step(1);
        i_addr_req = 1'b0;
        step(3);
        n_cmp++;
        if (o_blk_addr_vld !== 1'b0 || o_free_cnt !== 9'd0) begin
            n_bad++; $display("FAIL empty_req: vld=%0b cnt=%0d, want 0 0", o_blk_addr_vld, o_free_cnt);
        end
        i_rel_vld = 1'b1; i_rel_addr = 12'h0A0;
        step(1);             // edge t
        i_rel_vld = 1'b0;
        n_cmp++;
        if (o_blk_addr_vld !== 1'b0 || o_free_cnt !== 9'd1) begin
            n_bad++; $display("FAIL rel_t: vld=%0b cnt=%0d, want 0 1", o_blk_addr_vld, o_free_cnt);
        end
        step(1);             // edge t+1
        n_cmp++;
        if (o_blk_addr_vld !== 1'b1 || o_blk_addr !== 12'h0A0 || o_free_cnt !== 9'd0) begin
            n_bad++; $display("FAIL rel_t1: vld=%0b addr=%03h cnt=%0d, want 1 0a0 0",
                              o_blk_addr_vld, o_blk_addr, o_free_cnt);
        end
        step(1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 100; i++) begin
            i_rel_vld = 1'b1; i_rel_addr = 12'(12'h100 + i * 16);
            step(1);
        end
        i_rel_vld = 1'b0;
        n_cmp++;
        if (o_free_cnt !== 9'd100) begin
            n_bad++; $display("FAIL fill100: got %0d want 100", o_free_cnt);
        end
        i_addr_req = 1'b1;
        step(1);             // edge k: request sampled
        i_addr_req = 1'b0;
        i_rel_vld = 1'b1; i_rel_addr = 12'h050;
        step(1);             // edge k+1: pop and push together
        i_rel_vld = 1'b0;
        n_cmp++;
        if (o_blk_addr_vld !== 1'b1 || o_blk_addr !== 12'h100 || o_free_cnt !== 9'd100) begin
            n_bad++; $display("FAIL simul: vld=%0b addr=%03h cnt=%0d, want 1 100 100",
                              o_blk_addr_vld, o_blk_addr, o_free_cnt);
        end
        for (int i = 1; i < 100; i++) begin
            request_one(12'(12'h100 + i * 16), "older");
        end
        request_one(12'h050, "simul_tail");
        n_cmp++;
        if (o_free_cnt !== 9'd0 || o_err !== 1'b0) begin
            n_bad++; $display("FAIL simul_end: cnt=%0d err=%0b, want 0 0", o_free_cnt, o_err);
        end
    endtask

    task automatic test_errors();
        // Release into a full list.
        reset_and_init();
        i_rel_vld = 1'b1; i_rel_addr = 12'h020;
        step(1);
        i_rel_vld = 1'b0;
        n_cmp++;
        if (o_err !== 1'b1 || o_free_cnt !== 9'd256) begin
            n_bad++; $display("FAIL rel_full: err=%0b cnt=%0d, want 1 256", o_err, o_free_cnt);
        end
        request_one(12'h000, "full_head");

        // Misaligned release.
        reset_and_init();
        request_one(12'h000, "mis_first");
        i_rel_vld = 1'b1; i_rel_addr = 12'h013;
        step(1);
        i_rel_vld = 1'b0;
        n_cmp++;
        if (o_err !== 1'b1 || o_free_cnt !== 9'd255) begin
            n_bad++; $display("FAIL rel_misaligned: err=%0b cnt=%0d, want 1 255", o_err, o_free_cnt);
        end
        request_one(12'h010, "mis_head");

        // Double request, then reset while a grant is on the outputs.
        reset_and_init();
        i_addr_req = 1'b1;
        step(2);             // edges k and k+1 both see a request
        i_addr_req = 1'b0;
        n_cmp++;
        if (o_blk_addr_vld !== 1'b1 || o_blk_addr !== 12'h000 || o_err !== 1'b1) begin
            n_bad++; $display("FAIL dbl_req: vld=%0b addr=%03h err=%0b, want 1 000 1", o_blk_addr_vld, o_blk_addr, o_err);
        end
        step(2);
        n_cmp++;
        if (o_blk_addr_vld !== 1'b0 || o_free_cnt !== 9'd255) begin
            n_bad++; $display("FAIL dbl_not_queued: vld=%0b cnt=%0d, want 0 255", o_blk_addr_vld, o_free_cnt);
        end
        request_one(12'h010, "pre_reset");
        i_rst = 1'b1;
        #1;
        n_cmp++;
        if ({o_blk_addr_vld, o_blk_addr, o_free_cnt, o_init_done, o_err} !== '0) begin
            n_bad++; $display("FAIL mid_reset: vld=%0b addr=%03h cnt=%0d done=%0b err=%0b, want all 0",
                              o_blk_addr_vld, o_blk_addr, o_free_cnt, o_init_done, o_err);
        end
        step(1);
        i_rst = 1'b0;
        step(1);
        n_cmp++;
        if (o_free_cnt !== 9'd1 || o_init_done !== 1'b0 || o_blk_addr_vld !== 1'b0) begin
            n_bad++; $display("FAIL restart: cnt=%0d done=%0b vld=%0b, want 1 0 0", o_free_cnt, o_init_done, o_blk_addr_vld);
        end
        i_rel_vld = 1'b1; i_rel_addr = 12'h040;
        step(1);
        i_rel_vld = 1'b0;
        n_cmp++;
        if (o_err !== 1'b1 || o_free_cnt !== 9'd2) begin
            n_bad++; $display("FAIL rel_in_init: err=%0b cnt=%0d, want 1 2", o_err, o_free_cnt);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        i_rst = 1'b1;
        i_addr_req = 1'b0;
        i_rel_vld = 1'b0;
        i_rel_addr = '0;
        test_reset();
        test_init_pending();
        test_grants();
        test_drain_release();
        test_back_to_back();
        test_errors();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
